hmmm_mem: RTL and testbench
===========================

# hmmm_mem

Unified 256×15-bit instruction/data memory with a serial program loader, sitting directly on the processor's memory bus (`Adr`, `MemWrite`, `MemData1`, `MemData2`). After reset it holds the processor in reset while a program image is shifted in word by word. It then releases the processor and serves combinational reads and phase-2 writes.

## Interface
Parameters:
- `DEPTH`, 256: number of words; address width is fixed at 8.
- `WORD_W`, 15: word width, split into `[14:8]` on `MemData1` and `[7:0]` on `MemData2`.

Ports:
- `ph1` in 1: phase 1 of the single two-phase system clock; registered state updates here.
- `ph2` in 1: phase 2 of the same clock; flop inputs and memory writes are captured here.
- `reset` in 1: synchronous, active-high, sampled during `ph2`.
- `load_start` in 1: one-cycle pulse that begins a load.
- `sdata` in 1: serial load bit, MSB first.
- `svalid` in 1: `sdata` is valid this cycle.
- `load_end` in 1: one-cycle pulse that ends a load early.
- `cpu_reset` out 1: reset to the processor.
- `load_busy` out 1: loader is active.
- `load_done` out 1: the last load completed.
- `Adr` in 8: processor address.
- `MemWrite` in 1: processor store strobe.
- `MemData1` out 7: `mem[Adr][14:8]`.
- `MemData2` inout 8: read data, or processor write data when `MemWrite=1`.
- `io_out` out 8: MMIO output register (only with `MMIO_EN`).
- `io_in` in 8: MMIO input (only with `MMIO_EN`).

## Operation
- Loader FSM states: IDLE, SHIFT, WRITE, DONE.
- Reset:
  - FSM goes to IDLE; bit counter = 0; address counter = 0.
  - `load_busy=0`, `load_done=0`, `cpu_reset=1`, `io_out=0`.
  - Memory contents are not cleared.
- IDLE:
  - `cpu_reset=1`.
  - `load_start` → SHIFT.
- SHIFT:
  - Each cycle with `svalid=1`, `sdata` shifts into the 15-bit shift register and the bit counter increments.
  - When the counter reaches 15 → WRITE.
  - `svalid=0` stalls the counter with no timeout.
- WRITE:
  - `mem[addr]` ← shift register; addr increments; bit counter clears.
  - If addr was 255 → DONE; otherwise → SHIFT.
  - Exactly one cycle.
- `load_end` in SHIFT:
  - → DONE.
  - A partial word (counter ≠ 0) is discarded.
  - Words already written are kept.
- `load_end` in WRITE: the write completes first, then → DONE.
- DONE:
  - `load_done=1`, `cpu_reset=0`.
  - `load_start` re-enters SHIFT: address counter = 0, `load_done=0`, `cpu_reset=1`.
- `load_busy` = state ∈ {SHIFT, WRITE}. `cpu_reset` = `reset` OR state ≠ DONE.
- Processor reads are combinational on `Adr`:
  - `MemData1 = mem[Adr][14:8]`.
  - `MemData2 = mem[Adr][7:0]`, driven only when `MemWrite=0`; high-Z otherwise.
- Processor writes:
  - When `MemWrite=1` and `cpu_reset=0`, `mem[Adr][7:0]` ← `MemData2` during `ph2`.
  - Bits `[14:8]` are unchanged.
- Processor writes are ignored while `cpu_reset=1`.
- The loader has exclusive write access during WRITE; the processor is in reset then, so there is no write conflict.
- `svalid` arriving in the same cycle as `load_end` is ignored.
- `reset` during a load aborts it: FSM goes to IDLE; already-written words remain.

## Timing
- Read latency is 0 cycles; `Adr` → `MemData1`/`MemData2` is purely combinational.
- A store is visible to a read from the same address in the next cycle.
- Load timing:
  - 15 `svalid` cycles plus 1 WRITE cycle per word.
  - A full 256-word image needs at least 4096 cycles after `load_start`.
- DONE is entered the cycle after the last WRITE. `cpu_reset` falls with the same `ph1` edge; the processor fetches `mem[0]` in the following cycle.
- Registered outputs (`load_busy`, `load_done`, `io_out`) change only on `ph1`.

## Configuration
- Macro: `HMMM_MMIO_EN`.
- Defined:
  - Address `0xFF` is I/O, not memory.
  - A store to `0xFF` loads `io_out` (visible next cycle).
  - A read of `0xFF` returns `MemData2 = io_in`, `MemData1 = 0`.
  - The loader can still write `mem[255]`, but the processor cannot read it back.
- Undefined:
  - `0xFF` is ordinary memory.
  - The `io_out`/`io_in` ports are absent.

## Structure
- Package `hmmm_mem_pkg` holds:
  - the `loader_state_t` enum (IDLE, SHIFT, WRITE, DONE);
  - the `WORD_W` and `ADR_W` constants;
  - `IO_ADDR = 8'hFF`;
  - the bit-count terminal value 15.
- One sub-module, `mem_loader`, contains the FSM, shift register, and bit/address counters. It outputs `wr_en`, `wr_adr`, `wr_word`, `cpu_reset`, and status.
- The top level holds the array, the read muxing, the tristate, and MMIO.

## Test plan
- Reset, then `load_start`, then 2 words `15'h7ABC` and `15'h0123` (30 `svalid` cycles), then `load_end` → `mem[0]=7ABC`, `mem[1]=0123`, `load_done=1`, `cpu_reset` falls; `Adr=1` gives `MemData1=7'h01`, `MemData2=8'h23`.
- Full 256-word load of the pattern word=addr → DONE entered automatically after `mem[255]`; counters have wrapped; no `load_end` needed.
- `load_end` after 7 bits of word 3 → words 0–2 kept, `mem[3]` unchanged from its prior value; DONE.
- `svalid` gaps of 5 cycles between every bit → word still assembled correctly; no extra writes.
- In DONE, store `MemWrite=1`, `Adr=8'h10`, `MemData2=8'h5A` → next cycle `MemData2=5A`, `MemData1` unchanged. The same store during `cpu_reset=1` leaves memory unchanged.
- With `HMMM_MMIO_EN`: store `8'hC3` to `0xFF` → `io_out=C3` next cycle; `io_in=8'h3C` → a read at `0xFF` gives `MemData2=3C`, `MemData1=0`.

Source files
------------

// File: rtl/hmmm_mem_pkg.sv
// Shared types and constants for the hmmm unified memory and its serial loader.
package hmmm_mem_pkg;

  localparam int WORD_W = 15;
  localparam int ADR_W  = 8;
  localparam logic [ADR_W-1:0] IO_ADDR  = 8'hFF;
  localparam logic [3:0]       BIT_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/hmmm_mem_if.sv
// Processor memory bus plus loader control/status. MemData2 is bidirectional
// and lives outside this bundle as a plain inout on the memory.
interface hmmm_mem_if;
  import hmmm_mem_pkg::*;

  logic                    load_start;
  logic                    sdata;
  logic                    svalid;
  logic                    load_end;
  logic                    cpu_reset;
  logic                    load_busy;
  logic                    load_done;
  logic [ADR_W-1:0]        Adr;
  logic                    MemWrite;
  logic [WORD_W-ADR_W-1:0] MemData1;

  modport master (
    output load_start, sdata, svalid, load_end, Adr, MemWrite,
    input  cpu_reset, load_busy, load_done, MemData1
  );

  modport slave (
    input  load_start, sdata, svalid, load_end, Adr, MemWrite,
    output cpu_reset, load_busy, load_done, MemData1
  );

endinterface

// File: rtl/mem_loader.sv
// Serial program loader: shifts 15-bit words in MSB first, writes them to
// consecutive addresses and holds the processor in reset until done.
module mem_loader
  import hmmm_mem_pkg::*;
(
  input  logic              ph1,
  input  logic              reset,
  input  logic              load_start,
  input  logic              sdata,
  input  logic              svalid,
  input  logic              load_end,
  output logic              wr_en,
  output logic [ADR_W-1:0]  wr_adr,
  output logic [WORD_W-1:0] wr_word,
  output logic              cpu_reset,
  output logic              load_busy,
  output logic              load_done
);

  loader_state_t     state_reg, state_next;
  logic [3:0]        bit_cnt_reg, bit_cnt_next;
  logic [ADR_W-1:0]  adr_cnt_reg, adr_cnt_next;
  logic [WORD_W-1:0] shift_reg, shift_next;

  always_ff @(posedge ph1) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      adr_cnt_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      adr_cnt_reg <= adr_cnt_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    adr_cnt_next = adr_cnt_reg;
    shift_next   = shift_reg;
    wr_en        = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (load_start) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
          adr_cnt_next = '0;
        end
      end
      SHIFT: begin
        // load_end wins over a coincident svalid; any partial word is dropped
        if (load_end) begin
          state_next   = DONE;
          bit_cnt_next = '0;
        end else if (svalid) begin
          shift_next   = {shift_reg[WORD_W-2:0], sdata};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == BIT_LAST - 4'd1) begin
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        wr_en        = 1'b1;
        adr_cnt_next = adr_cnt_reg + 8'd1;
        bit_cnt_next = '0;
        if (adr_cnt_reg == '1 || load_end) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_adr    = adr_cnt_reg;
  assign wr_word   = shift_reg;
  assign load_busy = (state_reg == SHIFT) || (state_reg == WRITE);
  assign load_done = (state_reg == DONE);
  assign cpu_reset = reset || (state_reg != DONE);

endmodule

// File: rtl/hmmm_mem.sv
// Unified 256x15 instruction/data memory on the hmmm processor bus.
// Define HMMM_MMIO_EN to map address 0xFF to the io_out/io_in registers.
module hmmm_mem #(
  parameter int DEPTH  = 256,
  parameter int WORD_W = 15
) (
  input  logic       ph1,
  input  logic       ph2,
  input  logic       reset,
`ifdef HMMM_MMIO_EN
  output logic [7:0] io_out,
  input  logic [7:0] io_in,
`endif
  hmmm_mem_if.slave  bus,
  inout  wire  [7:0] MemData2
);
  import hmmm_mem_pkg::*;

  logic [WORD_W-1:0] mem_reg [DEPTH];
  logic              ld_wr_en;
  logic [ADR_W-1:0]  ld_wr_adr;
  logic [WORD_W-1:0] ld_wr_word;
  logic              cpu_reset;
  logic              io_sel;
  logic              cpu_store;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-9:0] rd_hi;
  logic [7:0]        rd_lo;

  mem_loader u_loader (
    .ph1        (ph1),
    .reset      (reset),
    .load_start (bus.load_start),
    .sdata      (bus.sdata),
    .svalid     (bus.svalid),
    .load_end   (bus.load_end),
    .wr_en      (ld_wr_en),
    .wr_adr     (ld_wr_adr),
    .wr_word    (ld_wr_word),
    .cpu_reset  (cpu_reset),
    .load_busy  (bus.load_busy),
    .load_done  (bus.load_done)
  );

  assign bus.cpu_reset = cpu_reset;

`ifdef HMMM_MMIO_EN
  assign io_sel = (bus.Adr == IO_ADDR);
`else
  assign io_sel = 1'b0;
`endif

  // The loader only writes while the processor is held in reset, so the
  // two write sources never collide.
  assign cpu_store = bus.MemWrite && !cpu_reset && !io_sel;

  always_ff @(posedge ph2) begin
    if (ld_wr_en) begin
      mem_reg[ld_wr_adr] <= ld_wr_word;
    end else if (cpu_store) begin
      mem_reg[bus.Adr][7:0] <= MemData2;
    end
  end

  assign rd_word = mem_reg[bus.Adr];

  always_comb begin
    rd_hi = rd_word[WORD_W-1:8];
    rd_lo = rd_word[7:0];
`ifdef HMMM_MMIO_EN
    if (io_sel) begin
      rd_hi = '0;
      rd_lo = io_in;
    end
`endif
  end

  assign bus.MemData1 = rd_hi;
  assign MemData2     = bus.MemWrite ? 8'hzz : rd_lo;

`ifdef HMMM_MMIO_EN
  always_ff @(posedge ph1) begin
    if (reset) begin
      io_out <= '0;
    end else if (bus.MemWrite && !cpu_reset && io_sel) begin
      io_out <= MemData2;
    end
  end
`endif

endmodule

// File: tb/tb_hmmm_mem.sv
// Scoreboard bench for hmmm_mem: loads images serially, then reads them back.
module tb_hmmm_mem;

  logic       ph1 = 1'b0;
  logic       ph2 = 1'b0;
  logic       reset;
  logic [7:0] md2_drv;
  wire  [7:0] MemData2;
`ifdef HMMM_MMIO_EN
  logic [7:0] io_out;
  logic [7:0] io_in;
`endif

  hmmm_mem_if bif ();

  assign MemData2 = bif.MemWrite ? md2_drv : 8'hzz;

  hmmm_mem dut (
    .ph1      (ph1),
    .ph2      (ph2),
    .reset    (reset),
`ifdef HMMM_MMIO_EN
    .io_out   (io_out),
    .io_in    (io_in),
`endif
    .bus      (bif),
    .MemData2 (MemData2)
  );

  // Non-overlapping two-phase clock, 20 time units per cycle.
  initial begin
    forever begin
      #5 ph1 = 1'b1;
      #5 ph1 = 1'b0;
      #5 ph2 = 1'b1;
      #5 ph2 = 1'b0;
    end
  end

  typedef struct {
    logic [7:0]  adr;
    logic [14:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [14:0] model_mem [256];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge ph1);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] adr);
`ifdef HMMM_MMIO_EN
    if (adr == 8'hFF) return;
`endif
    exp_q.push_back('{adr: adr, word: model_mem[adr]});
  endtask

  task automatic load_word(input logic [7:0] adr, input logic [14:0] w, input int gap);
    for (int i = 14; i >= 0; i--) begin
      bif.svalid = 1'b1;
      bif.sdata  = w[i];
      cycle();
      bif.svalid = 1'b0;
      repeat (gap) cycle();
    end
    cycle();
    model_mem[adr] = w;
    push_exp(adr);
    $display("load adr=%02h word=%04h", adr, w);
  endtask

  task automatic start_load();
    bif.load_start = 1'b1;
    cycle();
    bif.load_start = 1'b0;
  endtask

  task automatic end_load();
    bif.load_end = 1'b1;
    cycle();
    bif.load_end = 1'b0;
  endtask

  task automatic store(input logic [7:0] adr, input logic [7:0] data, input bit taken);
    bif.MemWrite = 1'b1;
    bif.Adr      = adr;
    md2_drv      = data;
    cycle();
    bif.MemWrite = 1'b0;
    if (taken) model_mem[adr][7:0] = data;
    $display("store adr=%02h data=%02h taken=%0d", adr, data, taken);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bif.MemWrite = 1'b0;
      bif.Adr      = e.adr;
      #1;
      $display("read adr=%02h hi=%02h lo=%02h", e.adr, bif.MemData1, MemData2);
      check($sformatf("rd_hi[%02h]", e.adr), 32'(bif.MemData1), 32'(e.word[14:8]));
      check($sformatf("rd_lo[%02h]", e.adr), 32'(MemData2), 32'(e.word[7:0]));
    end
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bif.load_start = 1'b0;
    bif.sdata      = 1'b0;
    bif.svalid     = 1'b0;
    bif.load_end   = 1'b0;
    bif.Adr        = '0;
    bif.MemWrite   = 1'b0;
    md2_drv        = '0;
`ifdef HMMM_MMIO_EN
    io_in          = '0;
`endif
    repeat (3) cycle();
    check("rst_cpu_reset", 32'(bif.cpu_reset), 32'd1);
    check("rst_busy", 32'(bif.load_busy), 32'd0);
    check("rst_done", 32'(bif.load_done), 32'd0);
`ifdef HMMM_MMIO_EN
    check("rst_io_out", 32'(io_out), 32'd0);
`endif
    reset = 1'b0;
    cycle();
    check("idle_cpu_reset", 32'(bif.cpu_reset), 32'd1);

    // Two words then an early end.
    start_load();
    check("t1_busy", 32'(bif.load_busy), 32'd1);
    check("t1_cpu_reset", 32'(bif.cpu_reset), 32'd1);
    load_word(8'h00, 15'h7ABC, 0);
    load_word(8'h01, 15'h0123, 0);
    end_load();
    check("t1_done", 32'(bif.load_done), 32'd1);
    check("t1_cpu_reset_low", 32'(bif.cpu_reset), 32'd0);
    check("t1_busy_low", 32'(bif.load_busy), 32'd0);
    drain();

    // Full image, DONE reached without load_end.
    start_load();
    for (int a = 0; a < 256; a++) begin
      load_word(8'(a), 15'(a), 0);
      if (a == 254) begin
        check("t2_done_early", 32'(bif.load_done), 32'd0);
        check("t2_busy_mid", 32'(bif.load_busy), 32'd1);
      end
    end
    check("t2_done", 32'(bif.load_done), 32'd1);
    check("t2_busy_low", 32'(bif.load_busy), 32'd0);
    check("t2_cpu_reset_low", 32'(bif.cpu_reset), 32'd0);
    drain();

    // load_end after 7 bits of word 3; a coincident svalid must be ignored.
    start_load();
    for (int k = 0; k < 3; k++) load_word(8'(k), 15'h6A00 + 15'(k), 0);
    for (int i = 0; i < 7; i++) begin
      bif.svalid = 1'b1;
      bif.sdata  = 1'b1;
      cycle();
    end
    bif.load_end = 1'b1;
    cycle();
    bif.load_end = 1'b0;
    bif.svalid   = 1'b0;
    check("t3_done", 32'(bif.load_done), 32'd1);
    push_exp(8'h03);
    push_exp(8'h04);
    drain();

    // Gappy serial stream.
    start_load();
    load_word(8'h00, 15'h2AD5, 5);
    check("t4_busy", 32'(bif.load_busy), 32'd1);
    load_word(8'h01, 15'h5B3C, 5);
    end_load();
    check("t4_done", 32'(bif.load_done), 32'd1);
    push_exp(8'h02);
    drain();

    // Processor stores in DONE.
    store(8'h10, 8'h5A, 1'b1);
    push_exp(8'h10);
    drain();
    store(8'h01, 8'hC7, 1'b1);
    push_exp(8'h01);
    drain();

`ifdef HMMM_MMIO_EN
    store(8'hFF, 8'hC3, 1'b0);
    check("io_out", 32'(io_out), 32'hC3);
    io_in   = 8'h3C;
    bif.Adr = 8'hFF;
    #1;
    check("io_rd_lo", 32'(MemData2), 32'h3C);
    check("io_rd_hi", 32'(bif.MemData1), 32'h0);
    cycle();
`endif

    // Stores while the processor is in reset are dropped.
    reset = 1'b1;
    cycle();
    check("t5_cpu_reset", 32'(bif.cpu_reset), 32'd1);
    store(8'h10, 8'hA5, 1'b0);
    reset = 1'b0;
    cycle();
    store(8'h01, 8'h11, 1'b0);
    push_exp(8'h10);
    push_exp(8'h01);
    drain();

    // Reset mid-load aborts but keeps written words.
    start_load();
    load_word(8'h00, 15'h0F0F, 0);
    for (int i = 0; i < 5; i++) begin
      bif.svalid = 1'b1;
      bif.sdata  = 1'b1;
      cycle();
    end
    bif.svalid = 1'b0;
    reset = 1'b1;
    cycle();
    check("t6_busy", 32'(bif.load_busy), 32'd0);
    check("t6_done", 32'(bif.load_done), 32'd0);
    check("t6_cpu_reset", 32'(bif.cpu_reset), 32'd1);
    reset = 1'b0;
    push_exp(8'h01);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
